// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the 64-word instruction memory and
// presents each fetched word plus its PC+4 to decode through a valid/ready register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [5:0]  IM_A,
  input  logic [31:0] IM_RD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetchState_t;

  fetchState_t stateR;
  fetchState_t nextStateS;
  logic [31:0] pcR;
  logic [31:0] pcNextS;
  logic [31:0] pcPlus4S;
  logic [31:0] instrR;
  logic [31:0] pc4R;
  logic        validR;
  logic        validNextS;
  logic        haltedR;
  logic [15:0] countR;
  logic        acceptS;
  logic        captureS;

  // Memory is word addressed and only 64 deep, so the PC wraps through it mod 64 words.
  assign IM_A        = pcR[7:2];
  assign instr_out   = instrR;
  assign pc4_out     = pc4R;
  assign valid_out   = validR;
  assign halted      = haltedR;
  assign fetch_count = countR;

  // Next-state, next-PC and handshake decode; redirect outranks capture and stall.
  always_comb begin
    pcPlus4S   = pcR + 32'd4;
    acceptS    = validR & ready_in;
    captureS   = (stateR == RUN) & (~validR | ready_in) & ~redirect_valid;
    nextStateS = stateR;
    pcNextS    = pcR;
    validNextS = validR;
    if (redirect_valid) begin
      nextStateS = RUN;
      pcNextS    = {redirect_target[31:2], 2'b00};
      validNextS = 1'b0;
    end else begin
      case (stateR)
        BOOT: begin
          nextStateS = RUN;
        end
        RUN: begin
          if (captureS) begin
            pcNextS    = pcPlus4S;
            validNextS = 1'b1;
            // The halt word itself is still handed to decode.
            if (IM_RD == HALT_WORD) begin
              nextStateS = HALTED;
            end else begin
              nextStateS = RUN;
            end
          end else begin
            validNextS = validR;
          end
        end
        HALTED: begin
          if (acceptS) begin
            validNextS = 1'b0;
          end else begin
            validNextS = validR;
          end
        end
        default: begin
          nextStateS = BOOT;
          validNextS = 1'b0;
        end
      endcase
    end
  end

  // State, PC, IF/ID register and accept counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stateR  <= BOOT;
      pcR     <= RESET_PC;
      instrR  <= 32'h0000_0000;
      pc4R    <= 32'h0000_0000;
      validR  <= 1'b0;
      haltedR <= 1'b0;
      countR  <= 16'h0000;
    end else begin
      stateR  <= nextStateS;
      pcR     <= pcNextS;
      validR  <= validNextS;
      haltedR <= (nextStateS == HALTED);
      if (captureS) begin
        instrR <= IM_RD;
        pc4R   <= pcPlus4S;
      end
      if (acceptS) begin
        countR <= countR + 16'd1;
      end
    end
  end

endmodule
